// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file with per-register ROB rename tags
// Commit writes values and retires matching tags; issue stamps tags; flush clears every tag.
module reg_file_rename #(
  parameter int REG_NUM = 32,
  parameter int REG_W   = 5,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic [TAG_W-1:0] rf_label1,
  output logic [TAG_W-1:0] rf_label2,
  output logic [XLEN-1:0]  rf_val1,
  output logic [XLEN-1:0]  rf_val2,
  input  logic             issue_en,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             commit_en,
  input  logic [REG_W-1:0] commit_rd,
  input  logic [XLEN-1:0]  commit_res,
  input  logic [TAG_W-1:0] commit_lab,
  input  logic             flush_in
);

  logic [XLEN-1:0]  val_q [REG_NUM];
  logic [XLEN-1:0]  val_d [REG_NUM];
  logic [TAG_W-1:0] tag_q [REG_NUM];
  logic [TAG_W-1:0] tag_d [REG_NUM];

  logic commit_ok;
  logic issue_ok;

  assign commit_ok = rdy_in && commit_en && (commit_rd != '0);
  assign issue_ok  = rdy_in && issue_en && (issue_rd != '0) && !flush_in;

  // Issue is applied after commit so a same-cycle issue to the same rd keeps its new tag.
  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (commit_ok) begin
      val_d[commit_rd] = commit_res;
      if (tag_q[commit_rd] == commit_lab) begin
        tag_d[commit_rd] = '0;
      end
    end
    if (rdy_in && flush_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        tag_d[i] = '0;
      end
    end else if (issue_ok) begin
      tag_d[issue_rd] = issue_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Retiring producer is forwarded so decode never captures a tag whose ROB entry is gone.
  always_comb begin
    rf_label1 = tag_q[rs1];
    rf_val1   = val_q[rs1];
    if (rs1 == '0) begin
      rf_label1 = '0;
      rf_val1   = '0;
    end else if (commit_ok && (commit_rd == rs1) && (tag_q[rs1] == commit_lab)) begin
      rf_label1 = '0;
      rf_val1   = commit_res;
    end
  end

  always_comb begin
    rf_label2 = tag_q[rs2];
    rf_val2   = val_q[rs2];
    if (rs2 == '0) begin
      rf_label2 = '0;
      rf_val2   = '0;
    end else if (commit_ok && (commit_rd == rs2) && (tag_q[rs2] == commit_lab)) begin
      rf_label2 = '0;
      rf_val2   = commit_res;
    end
  end

endmodule
